// File: rtl/fmap_pkg.sv
// ---------------------------------------------------------------------------
// fmap_pkg
// Shared types and helpers for the feature-map capture / display blocks.
//   state_e        : capture FSM states (IDLE, CAPTURE, WRITE)
//   words_per_map  : number of BRAM words needed to hold one packed map
//   fp16_to_gray   : fp16 -> 8-bit greyscale with a signed power-of-two gain
// ---------------------------------------------------------------------------
package fmap_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        WRITE   = 2'd2
    } state_e;

    localparam logic [7:0] GRAY_MAX = 8'hFF;

    // Ceiling division: the last word may be only partly filled.
    function automatic int words_per_map(input int w, input int h, input int ppw);
        return (w * h + ppw - 1) / ppw;
    endfunction

    // gray = clamp(floor(x * 2^(8+gain)), 0, 255).
    // The 11-bit mantissa (hidden one included) is scaled by
    // 2^(exp-15+8+gain-10). Since the mantissa is always >= 1024, any
    // non-negative shift already exceeds 255 and saturates.
    function automatic logic [7:0] fp16_to_gray(input logic [15:0]       x,
                                                input logic signed [2:0] gain);
        logic [4:0]  e;
        logic [10:0] m;
        logic [10:0] v;
        logic [7:0]  g;
        int          sh;
        e  = x[14:10];
        m  = {1'b1, x[9:0]};
        sh = int'(e) - 17 + int'(gain);
        v  = '0;
        g  = '0;
        if (x[15]) begin
            g = '0;
        end else if (e == 5'd0) begin
            g = '0;
        end else if (e == 5'd31) begin
            g = GRAY_MAX;
        end else if (sh >= 0) begin
            g = GRAY_MAX;
        end else begin
            v = m >> (-sh);
            g = (v > 11'd255) ? GRAY_MAX : v[7:0];
        end
        return g;
    endfunction

endpackage

// File: rtl/fmap_capture_mc_pack_word.sv
// ---------------------------------------------------------------------------
// fmap_pack_word
// Combinational packer: selects word `word_idx_i` of the row-major pixel
// buffer. Byte i of the word is pixel word_idx_i*PPW + i; positions past the
// end of the map are zero.
//   pix_i      : flat pixel buffer, pixel p at bits [p*PIX_BITS +: PIX_BITS]
//   word_idx_i : word index within the map
//   wdata_o    : packed BRAM word
// ---------------------------------------------------------------------------
module fmap_pack_word #(
    parameter int NPIX     = 576,
    parameter int PPW      = 32,
    parameter int PIX_BITS = 8,
    parameter int WC_W     = 5
) (
    input  logic [NPIX*PIX_BITS-1:0] pix_i,
    input  logic [WC_W-1:0]          word_idx_i,
    output logic [PPW*PIX_BITS-1:0]  wdata_o
);

    always_comb begin
        wdata_o = '0;
        for (int i = 0; i < PPW; i++) begin
            if (int'(word_idx_i) * PPW + i < NPIX) begin
                wdata_o[i*PIX_BITS +: PIX_BITS] =
                    pix_i[(int'(word_idx_i) * PPW + i) * PIX_BITS +: PIX_BITS];
            end
        end
    end

endmodule

// File: rtl/fmap_capture_mc.sv
// ---------------------------------------------------------------------------
// fmap_capture_mc
// Captures an fp16 feature map column by column (tagged with a channel),
// converts each pixel to 8-bit greyscale, buffers the whole map, then writes
// it row-major into the display BRAM at the channel's slot.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   col_valid/col_ready : column handshake (ready low while writing)
//   col_ch, gain        : channel and gain exponent, taken from column 0
//   col_data            : fp16 column, element r (bits 16r+:16) = row r
//   bram_addr/wdata/we  : registered BRAM write port, one word per cycle
//   done, done_ch       : 1-cycle completion pulse and its channel
//   err_ch              : sticky flag, out-of-range channel seen on column 0
// ---------------------------------------------------------------------------
module fmap_capture_mc
    import fmap_pkg::*;
#(
    parameter int PIX_W     = 24,
    parameter int PIX_H     = 24,
    parameter int NUM_CH    = 4,
    parameter int PIX_BITS  = 8,
    parameter int BRAM_W    = 256,
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0,
    parameter int CH_STRIDE = 18,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   col_valid,
    output logic                   col_ready,
    input  logic [CH_W-1:0]        col_ch,
    input  logic [16*PIX_H-1:0]    col_data,
    input  logic signed [2:0]      gain,
    output logic [ADDR_W-1:0]      bram_addr,
    output logic [BRAM_W-1:0]      bram_wdata,
    output logic                   bram_we,
    output logic                   done,
    output logic [CH_W-1:0]        done_ch,
    output logic                   err_ch
);

    localparam int PPW  = BRAM_W / PIX_BITS;
    localparam int NPIX = PIX_W * PIX_H;
    localparam int WPM  = words_per_map(PIX_W, PIX_H, PPW);
    localparam int CC_W = $clog2(PIX_W + 1);
    localparam int WC_W = (WPM > 1) ? $clog2(WPM) : 1;

    if (PIX_BITS != 8) begin : g_bad_pix_bits
        $error("fmap_capture_mc: PIX_BITS must be 8");
    end
    if (BRAM_W % PIX_BITS != 0) begin : g_bad_bram_w
        $error("fmap_capture_mc: BRAM_W must be a multiple of PIX_BITS");
    end
    if (CH_STRIDE < WPM) begin : g_bad_stride
        $error("fmap_capture_mc: CH_STRIDE smaller than words per map");
    end

    state_e                 state_q, state_d;
    logic [CC_W-1:0]        col_cnt_q, col_cnt_d;
    logic [WC_W-1:0]        wr_cnt_q, wr_cnt_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic signed [2:0]      gain_q, gain_d;
    logic [NPIX*8-1:0]      pix_q, pix_d;
    logic                   we_q, we_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [BRAM_W-1:0]      wdata_q, wdata_d;
    logic                   done_q, done_d;
    logic [CH_W-1:0]        done_ch_q, done_ch_d;
    logic                   err_q, err_d;

    logic                   accept;
    logic                   store;
    logic                   load_word;
    logic signed [2:0]      gain_eff;
    logic [7:0]             gray [PIX_H];
    logic [BRAM_W-1:0]      pack_word;

    assign col_ready  = (state_q != WRITE);
    assign accept     = col_valid && col_ready;

    // Column 0 is converted with the gain on the bus; later columns use
    // the gain latched with column 0.
    assign gain_eff   = (state_q == IDLE) ? gain : gain_q;

    always_comb begin
        for (int r = 0; r < PIX_H; r++) begin
            gray[r] = fp16_to_gray(col_data[16*r +: 16], gain_eff);
        end
    end

    // Buffer image after this cycle's store. The first word is packed from
    // it so the column accepted on the entry edge into WRITE is included.
    always_comb begin
        pix_d = pix_q;
        if (store) begin
            for (int r = 0; r < PIX_H; r++) begin
                pix_d[(r * PIX_W + int'(col_cnt_q)) * 8 +: 8] = gray[r];
            end
        end
    end

    fmap_pack_word #(
        .NPIX     (NPIX),
        .PPW      (PPW),
        .PIX_BITS (PIX_BITS),
        .WC_W     (WC_W)
    ) u_pack (
        .pix_i      (pix_d),
        .word_idx_i (wr_cnt_d),
        .wdata_o    (pack_word)
    );

    // Next-state logic. The BRAM outputs are loaded one edge ahead, so
    // bram_we is high exactly during the WPM cycles spent in WRITE and
    // done lands in the first IDLE cycle.
    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        ch_d      = ch_q;
        gain_d    = gain_q;
        done_d    = 1'b0;
        done_ch_d = done_ch_q;
        err_d     = err_q;
        store     = 1'b0;
        load_word = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (int'(col_ch) >= NUM_CH) begin
                        err_d = 1'b1;
                    end else begin
                        store     = 1'b1;
                        ch_d      = col_ch;
                        gain_d    = gain;
                        col_cnt_d = CC_W'(1);
                        if (PIX_W == 1) begin
                            state_d   = WRITE;
                            wr_cnt_d  = '0;
                            load_word = 1'b1;
                        end else begin
                            state_d = CAPTURE;
                        end
                    end
                end
            end
            CAPTURE: begin
                if (accept) begin
                    store     = 1'b1;
                    col_cnt_d = col_cnt_q + CC_W'(1);
                    if (col_cnt_q == CC_W'(PIX_W - 1)) begin
                        state_d   = WRITE;
                        wr_cnt_d  = '0;
                        load_word = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (wr_cnt_q == WC_W'(WPM - 1)) begin
                    state_d   = IDLE;
                    col_cnt_d = '0;
                    done_d    = 1'b1;
                    done_ch_d = ch_q;
                end else begin
                    wr_cnt_d  = wr_cnt_q + WC_W'(1);
                    load_word = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        we_d    = load_word;
        addr_d  = load_word
                  ? ADDR_W'(BASE_ADDR + int'(ch_d) * CH_STRIDE + int'(wr_cnt_d))
                  : addr_q;
        wdata_d = load_word ? pack_word : wdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            col_cnt_q <= '0;
            wr_cnt_q  <= '0;
            ch_q      <= '0;
            gain_q    <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
            done_ch_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            ch_q      <= ch_d;
            gain_q    <= gain_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            done_q    <= done_d;
            done_ch_q <= done_ch_d;
            err_q     <= err_d;
        end
    end

    // Pixel storage carries no reset; its contents only matter once a full
    // map has been captured.
    always_ff @(posedge clk) begin
        pix_q <= pix_d;
    end

    assign bram_we    = we_q;
    assign bram_addr  = addr_q;
    assign bram_wdata = wdata_q;
    assign done       = done_q;
    assign done_ch    = done_ch_q;
    assign err_ch     = err_q;

endmodule

// File: tb/tb_fmap_capture_mc.sv
// ---------------------------------------------------------------------------
// tb_fmap_capture_mc
// Drives a full-size instance (24x24, 4 channels) and a small instance
// (5x5, 3 channels) and compares BRAM traffic against a real-arithmetic
// greyscale model and a row-major packing model.
// ---------------------------------------------------------------------------
module tb_fmap_capture_mc;

    localparam int W = 24, H = 24, WPM = 18, STRIDE = 18;
    localparam int SW = 5, SH = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic              col_valid, col_ready, bram_we, done, err_ch;
    logic [1:0]        col_ch, done_ch;
    logic [16*H-1:0]   col_data;
    logic signed [2:0] gain;
    logic [11:0]       bram_addr;
    logic [255:0]      bram_wdata;

    logic              s_col_valid, s_col_ready, s_bram_we, s_done, s_err_ch;
    logic [1:0]        s_col_ch, s_done_ch;
    logic [16*SH-1:0]  s_col_data;
    logic signed [2:0] s_gain;
    logic [11:0]       s_bram_addr;
    logic [255:0]      s_bram_wdata;

    fmap_capture_mc dut (
        .clk(clk), .rst(rst), .col_valid(col_valid), .col_ready(col_ready),
        .col_ch(col_ch), .col_data(col_data), .gain(gain),
        .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_we(bram_we),
        .done(done), .done_ch(done_ch), .err_ch(err_ch)
    );

    fmap_capture_mc #(.PIX_W(SW), .PIX_H(SH), .NUM_CH(3)) dut_s (
        .clk(clk), .rst(rst), .col_valid(s_col_valid), .col_ready(s_col_ready),
        .col_ch(s_col_ch), .col_data(s_col_data), .gain(s_gain),
        .bram_addr(s_bram_addr), .bram_wdata(s_bram_wdata), .bram_we(s_bram_we),
        .done(s_done), .done_ch(s_done_ch), .err_ch(s_err_ch)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] fp    [H][W];
    int          exp_g [H][W];
    logic [15:0] sfp   [SH][SW];
    int          s_exp_g [SH][SW];

    int           wq_addr[$];
    logic [255:0] wq_data[$];
    int  done_cnt = 0, done_ch_last = 0, done_prev_addr = 0;
    bit  done_prev_we = 0, done_we_now = 0;
    bit  prev_we = 0;
    int  prev_addr = 0;
    int           s_wq_addr[$];
    logic [255:0] s_wq_data[$];
    int  s_done_cnt = 0, s_done_ch_last = 0;

    // BRAM / done observers, sampled on the falling edge.
    always @(negedge clk) begin
        if (bram_we === 1'b1) begin
            wq_addr.push_back(int'(bram_addr));
            wq_data.push_back(bram_wdata);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_ch_last   = int'(done_ch);
            done_prev_we   = prev_we;
            done_prev_addr = prev_addr;
            done_we_now    = bram_we;
        end
        prev_we   = (bram_we === 1'b1);
        prev_addr = int'(bram_addr);
        if (s_bram_we === 1'b1) begin
            s_wq_addr.push_back(int'(s_bram_addr));
            s_wq_data.push_back(s_bram_wdata);
        end
        if (s_done === 1'b1) begin
            s_done_cnt++;
            s_done_ch_last = int'(s_done_ch);
        end
    end

    // ---------------- reference model ----------------
    function automatic int ref_gray(input logic [15:0] x, input int g);
        int  e;
        real v;
        e = int'(x[14:10]);
        if (x[15]) return 0;
        if (e == 0) return 0;
        if (e == 31) return 255;
        v = (1.0 + real'(x[9:0]) / 1024.0) * $pow(2.0, real'(e - 15 + 8 + g));
        if (v >= 255.0) return 255;
        return int'($floor(v));
    endfunction

    function automatic logic [15:0] fp_for_gray(input int g);
        int k;
        k = 0;
        if (g == 0) return 16'h0000;
        for (int b = 0; b < 8; b++) if (((g >> b) & 1) == 1) k = b;
        return {1'b0, 5'(k + 7), 10'((g << (10 - k)) & 'h3FF)};
    endfunction

    function automatic logic [15:0] rand_fp();
        if ($urandom_range(0, 1) == 0) return 16'($urandom);
        return {1'b0, 5'($urandom_range(8, 18)), 10'($urandom)};
    endfunction

    function automatic logic [255:0] exp_word(input int w);
        logic [255:0] d;
        int p;
        d = '0;
        for (int i = 0; i < 32; i++) begin
            p = w * 32 + i;
            if (p < W * H) d[i*8 +: 8] = 8'(exp_g[p / W][p % W]);
        end
        return d;
    endfunction

    function automatic logic [255:0] s_exp_word();
        logic [255:0] d;
        d = '0;
        for (int p = 0; p < SW * SH; p++) d[p*8 +: 8] = 8'(s_exp_g[p / SW][p % SW]);
        return d;
    endfunction

    task automatic fill_random();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) fp[r][c] = rand_fp();
    endtask

    task automatic fill_expected(input int g);
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) exp_g[r][c] = ref_gray(fp[r][c], g);
    endtask

    // ---------------- stimulus ----------------
    task automatic applyStimulus(input int ch, input int g, input bit gaps,
                                 input int first, input int last);
        int guard;
        for (int c = first; c <= last; c++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                col_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            col_valid = 1'b1;
            col_ch    = (c == 0) ? 2'(ch) : 2'($urandom);
            gain      = (c == 0) ? 3'(g)  : 3'($urandom);
            for (int r = 0; r < H; r++) col_data[16*r +: 16] = fp[r][c];
            guard = 0;
            while (col_ready !== 1'b1 && guard < 100) begin
                @(posedge clk); #1; guard++;
            end
            if (guard >= 100) begin
                n_checks++; n_fail++;
                $display("[TB] FAIL ready_timeout col=%0d ready=%b required 1", c, col_ready);
            end
            @(posedge clk); #1;
        end
        col_valid = 1'b0;
    endtask

    task automatic send_small(input int ch, input int g);
        for (int c = 0; c < SW; c++) begin
            s_col_valid = 1'b1;
            s_col_ch    = (c == 0) ? 2'(ch) : 2'($urandom);
            s_gain      = (c == 0) ? 3'(g)  : 3'($urandom);
            for (int r = 0; r < SH; r++) s_col_data[16*r +: 16] = sfp[r][c];
            @(posedge clk); #1;
        end
        s_col_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int guard;
        guard = 0;
        while (done_cnt < target && guard < 300) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 300) begin
            n_checks++; n_fail++;
            $display("[TB] FAIL done_timeout done_cnt=%0d required %0d", done_cnt, target);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({col_ready, bram_we, done, err_ch, done_ch, bram_addr} !== {4'b1000, 2'b00, 12'h000}) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl got rdy=%b we=%b done=%b err=%b dch=%0d addr=%0d required 1 0 0 0 0 0",
                     col_ready, bram_we, done, err_ch, done_ch, bram_addr);
        end
        n_checks++;
        if (bram_wdata !== '0) begin
            n_fail++; $display("[TB] FAIL reset_wdata got %h required 0", bram_wdata);
        end
        n_checks++;
        if ({s_col_ready, s_bram_we, s_done, s_err_ch} !== 4'b1000) begin
            n_fail++;
            $display("[TB] FAIL reset_small got %b required 1000", {s_col_ready, s_bram_we, s_done, s_err_ch});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_half_map();
        int d0;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) fp[r][c] = 16'h3800;
        wq_addr.delete(); wq_data.delete();
        d0 = done_cnt;
        applyStimulus(2, 0, 1'b0, 0, W - 1);
        wait_done(d0 + 1);
        n_checks++;
        if (wq_addr.size() != WPM) begin
            n_fail++; $display("[TB] FAIL half_count got %0d required %0d", wq_addr.size(), WPM);
        end
        for (int w = 0; w < wq_addr.size() && w < WPM; w++) begin
            n_checks++;
            if (wq_addr[w] != 36 + w || wq_data[w] !== {32{8'h80}}) begin
                n_fail++;
                $display("[TB] FAIL half_word%0d got addr=%0d data=%h required addr=%0d data=all 80",
                         w, wq_addr[w], wq_data[w], 36 + w);
            end
        end
        n_checks++;
        if (done_cnt != d0 + 1 || done_ch_last != 2 || !done_prev_we || done_prev_addr != 53 || done_we_now) begin
            n_fail++;
            $display("[TB] FAIL half_done got n=%0d ch=%0d prev_we=%b prev_addr=%0d we=%b required n=%0d ch=2 1 53 0",
                     done_cnt - d0, done_ch_last, done_prev_we, done_prev_addr, done_we_now, 1);
        end
    endtask

    task automatic test_conversion();
        int g, ch, d0;
        for (int it = 0; it < 3; it++) begin
            fill_random();
            g  = (it == 0) ? 0 : (it == 1) ? -1 : int'($urandom_range(0, 7)) - 4;
            ch = int'($urandom_range(0, 3));
            if (it == 0) begin
                fp[0][0] = 16'h3C00; fp[0][1] = 16'hBC00; fp[0][2] = 16'h7C00; fp[0][3] = 16'h0001;
            end
            if (it == 1) fp[0][0] = 16'h3800;
            fill_expected(g);
            wq_addr.delete(); wq_data.delete();
            d0 = done_cnt;
            applyStimulus(ch, g, 1'b1, 0, W - 1);
            wait_done(d0 + 1);
            n_checks++;
            if (wq_addr.size() != WPM || done_ch_last != ch) begin
                n_fail++;
                $display("[TB] FAIL conv%0d_count got n=%0d ch=%0d required %0d ch=%0d", it, wq_addr.size(), done_ch_last, WPM, ch);
            end
            for (int w = 0; w < wq_addr.size() && w < WPM; w++) begin
                n_checks++;
                if (wq_addr[w] != ch * STRIDE + w || wq_data[w] !== exp_word(w)) begin
                    n_fail++;
                    $display("[TB] FAIL conv%0d_word%0d got addr=%0d data=%h required addr=%0d data=%h",
                             it, w, wq_addr[w], wq_data[w], ch * STRIDE + w, exp_word(w));
                end
            end
            if (wq_data.size() > 0) begin
                n_checks++;
                if (it == 0 && wq_data[0][31:0] !== 32'h00FF00FF) begin
                    n_fail++; $display("[TB] FAIL conv_special got %h required 00ff00ff", wq_data[0][31:0]);
                end else if (it == 1 && wq_data[0][7:0] !== 8'h40) begin
                    n_fail++; $display("[TB] FAIL conv_gain_m1 got %h required 40", wq_data[0][7:0]);
                end
            end
        end
    endtask

    task automatic test_row_major();
        int d0;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) fp[r][c] = fp_for_gray((r * W + c) & 255);
        fill_expected(0);
        wq_addr.delete(); wq_data.delete();
        d0 = done_cnt;
        applyStimulus(1, 0, 1'b1, 0, W - 1);
        wait_done(d0 + 1);
        for (int w = 0; w < wq_addr.size() && w < WPM; w++) begin
            n_checks++;
            if (wq_addr[w] != STRIDE + w || wq_data[w] !== exp_word(w)) begin
                n_fail++;
                $display("[TB] FAIL rowmaj_word%0d got addr=%0d data=%h required addr=%0d data=%h",
                         w, wq_addr[w], wq_data[w], STRIDE + w, exp_word(w));
            end
        end
        n_checks++;
        if (wq_data.size() != WPM) begin
            n_fail++; $display("[TB] FAIL rowmaj_count got %0d required %0d", wq_data.size(), WPM);
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (wq_data[17][i*8 +: 8] !== 8'(32 + i)) begin
                    n_fail++;
                    $display("[TB] FAIL rowmaj_w17_b%0d got %h required %h", i, wq_data[17][i*8 +: 8], 8'(32 + i));
                    break;
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] exp_a [WPM];
        int d0, zeros, ga, gb;
        ga = int'($urandom_range(0, 7)) - 4;
        gb = int'($urandom_range(0, 7)) - 4;
        fill_random();
        fill_expected(ga);
        for (int w = 0; w < WPM; w++) exp_a[w] = exp_word(w);
        wq_addr.delete(); wq_data.delete();
        d0 = done_cnt;
        applyStimulus(3, ga, 1'b0, 0, W - 1);
        fill_random();
        fill_expected(gb);
        col_valid = 1'b1; col_ch = 2'd1; gain = 3'(gb);
        for (int r = 0; r < H; r++) col_data[16*r +: 16] = fp[r][0];
        zeros = 0;
        while (col_ready !== 1'b1 && zeros < 100) begin
            zeros++; @(posedge clk); #1;
        end
        n_checks++;
        if (zeros != WPM || done !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL bp_ready_low got %0d cycles done=%b required %0d done=1", zeros, done, WPM);
        end
        @(posedge clk); #1;
        applyStimulus(1, gb, 1'b1, 1, W - 1);
        wait_done(d0 + 2);
        n_checks++;
        if (wq_addr.size() != 2 * WPM || done_cnt != d0 + 2 || done_ch_last != 1) begin
            n_fail++;
            $display("[TB] FAIL bp_count got writes=%0d dones=%0d ch=%0d required %0d 2 1",
                     wq_addr.size(), done_cnt - d0, done_ch_last, 2 * WPM);
        end
        for (int w = 0; w < wq_addr.size() && w < 2 * WPM; w++) begin
            n_checks++;
            if (w < WPM ? (wq_addr[w] != 3 * STRIDE + w || wq_data[w] !== exp_a[w])
                        : (wq_addr[w] != STRIDE + w - WPM || wq_data[w] !== exp_word(w - WPM))) begin
                n_fail++;
                $display("[TB] FAIL bp_word%0d got addr=%0d data=%h", w, wq_addr[w], wq_data[w]);
            end
        end
    endtask

    task automatic test_err_and_padding();
        int g;
        s_wq_addr.delete(); s_wq_data.delete();
        s_col_valid = 1'b1; s_col_ch = 2'd3; s_gain = '0;
        @(posedge clk); #1;
        s_col_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (s_err_ch !== 1'b1 || s_col_ready !== 1'b1 || s_wq_addr.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL err_set got err=%b rdy=%b writes=%0d required 1 1 0", s_err_ch, s_col_ready, s_wq_addr.size());
        end
        for (int it = 0; it < 2; it++) begin
            g = int'($urandom_range(0, 7)) - 4;
            for (int r = 0; r < SH; r++) for (int c = 0; c < SW; c++) begin
                sfp[r][c] = rand_fp();
                s_exp_g[r][c] = ref_gray(sfp[r][c], g);
            end
            s_wq_addr.delete(); s_wq_data.delete();
            send_small(it * 2, g);
            repeat (5) @(posedge clk);
            #1;
            n_checks++;
            if (s_wq_addr.size() != 1 || s_done_ch_last != it * 2 || s_err_ch !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL small%0d_status got writes=%0d ch=%0d err=%b required 1 %0d 1",
                         it, s_wq_addr.size(), s_done_ch_last, s_err_ch, it * 2);
            end else begin
                n_checks++;
                if (s_wq_addr[0] != it * 36 || s_wq_data[0] !== s_exp_word()) begin
                    n_fail++;
                    $display("[TB] FAIL small%0d_word got addr=%0d data=%h required addr=%0d data=%h",
                             it, s_wq_addr[0], s_wq_data[0], it * 36, s_exp_word());
                end
                n_checks++;
                if (s_wq_data[0][255:200] !== '0) begin
                    n_fail++; $display("[TB] FAIL small%0d_pad got %h required 0", it, s_wq_data[0][255:200]);
                end
            end
        end
        n_checks++;
        if (s_done_cnt != 2) begin
            n_fail++; $display("[TB] FAIL small_dones got %0d required 2", s_done_cnt);
        end
    endtask

    task automatic checkOutput(input string name, input int d_expect, input int w_expect, input int d0);
        n_checks++;
        if (done_cnt != d0 + d_expect || wq_addr.size() != w_expect) begin
            n_fail++;
            $display("[TB] FAIL %s got dones=%0d writes=%0d required %0d %0d",
                     name, done_cnt - d0, wq_addr.size(), d_expect, w_expect);
        end
    endtask

    task automatic test_reset_mid();
        int d0, guard;
        // Abort during capture.
        fill_random();
        wq_addr.delete(); wq_data.delete();
        d0 = done_cnt;
        applyStimulus(0, 0, 1'b0, 0, 9);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (s_err_ch !== 1'b0 || col_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL rst_clear got s_err=%b rdy=%b required 0 1", s_err_ch, col_ready);
        end
        repeat (40) @(posedge clk);
        #1;
        checkOutput("rst_capture_abort", 0, 0, d0);
        // Abort during the write phase.
        applyStimulus(2, 0, 1'b0, 0, W - 1);
        guard = 0;
        while (wq_addr.size() < 5 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (bram_we !== 1'b0 || guard >= 50) begin
            n_fail++; $display("[TB] FAIL rst_we_drop got we=%b guard=%0d required 0", bram_we, guard);
        end
        repeat (30) @(posedge clk);
        #1;
        n_checks++;
        if (done_cnt != d0 || wq_addr.size() < 5 || wq_addr.size() >= WPM) begin
            n_fail++;
            $display("[TB] FAIL rst_write_abort got dones=%0d writes=%0d required 0 and partial",
                     done_cnt - d0, wq_addr.size());
        end
        // Fresh map afterwards completes normally.
        fill_random();
        fill_expected(1);
        wq_addr.delete(); wq_data.delete();
        applyStimulus(0, 1, 1'b1, 0, W - 1);
        wait_done(d0 + 1);
        checkOutput("rst_fresh_map", 1, WPM, d0);
        for (int w = 0; w < wq_addr.size() && w < WPM; w++) begin
            n_checks++;
            if (wq_addr[w] != w || wq_data[w] !== exp_word(w)) begin
                n_fail++;
                $display("[TB] FAIL rst_fresh_word%0d got addr=%0d data=%h required addr=%0d data=%h",
                         w, wq_addr[w], wq_data[w], w, exp_word(w));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        col_valid = 1'b0; col_ch = '0; col_data = '0; gain = '0;
        s_col_valid = 1'b0; s_col_ch = '0; s_col_data = '0; s_gain = '0;
        test_reset();
        test_half_map();
        test_conversion();
        test_row_major();
        test_back_to_back();
        test_err_and_padding();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "[TB] watchdog");
    end

endmodule
